// File: rtl/mem_stage_mc_if.sv
// Bus between the EX/MEM register side and the multi-cycle memory stage.
interface mem_stage_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_in;
  logic              writeEn;
  logic              readEn;
  logic              memToReg;
  logic              stall;
  logic              wb_valid;
  logic              misalign;
  logic [DATA_W-1:0] regWriteData;

  modport master (
    output mem_addr, data_in, writeEn, readEn, memToReg,
    input  stall, wb_valid, misalign, regWriteData
  );

  modport slave (
    input  mem_addr, data_in, writeEn, readEn, memToReg,
    output stall, wb_valid, misalign, regWriteData
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: word-addressed data array with a fixed access
// latency, pipeline stall generation, read data latch and writeback mux.
module mem_stage_mc #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int ADDR_LSB   = 1
) (
  input logic           clk,
  input logic           rst_n,
  mem_stage_mc_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = 4;
  // The cycle in which the request is accepted counts as the first latency
  // cycle, so BUSY lasts LATENCY-1 cycles and the stall totals LATENCY.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  wr_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  misalign_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  req;
  logic                  wr_in;
  logic                  offset_nz;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic                  commit;
  logic                  c_wr;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [DATA_W-1:0]     c_data;

  assign req    = bus.readEn | bus.writeEn;
  assign wr_in  = bus.writeEn & ~bus.readEn;
  assign idx_in = bus.mem_addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];

  generate
    if (ADDR_LSB > 0) begin : g_offset
      assign offset_nz = |bus.mem_addr[ADDR_LSB-1:0];
    end else begin : g_no_offset
      assign offset_nz = 1'b0;
    end
  endgenerate

  // Decide whether the array is committed at the coming edge, and with which
  // operands: live inputs for a single-cycle access, latched copy otherwise.
  always_comb begin
    commit = 1'b0;
    c_idx  = idx_q;
    c_data = wdata_q;
    c_wr   = wr_q;
    if (state == IDLE) begin
      c_idx  = idx_in;
      c_data = bus.data_in;
      c_wr   = wr_in;
      if (LATENCY == 1 && req) begin
        commit = 1'b1;
      end
    end else if (state == BUSY && cnt == '0) begin
      commit = 1'b1;
    end
  end

  // Control FSM: accept, count down the latency, then a single DONE cycle;
  // also latches the request and captures read data on a read commit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q      <= idx_in;
            wdata_q    <= bus.data_in;
            wr_q       <= wr_in;
            misalign_q <= offset_nz;
            cnt        <= CNT_INIT;
            state      <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !c_wr) begin
        rdata_q <= mem_q[c_idx];
      end
    end
  end

  // Data array: cleared on reset, written only when a store commits.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && c_wr) begin
      mem_q[c_idx] <= c_data;
    end
  end

  assign bus.stall        = ((state == IDLE) && req) || (state == BUSY);
  assign bus.wb_valid     = (state == DONE);
  assign bus.misalign     = misalign_q;
  assign bus.regWriteData = bus.memToReg ? rdata_q : DATA_W'(bus.mem_addr);
endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: directed vector table, reset abort,
// randomized ops against a transaction-level model, and a LATENCY=1 build.
module tb_mem_stage_mc;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;

  mem_stage_mc_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  mem_stage_mc_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(LAT), .ADDR_LSB(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1), .ADDR_LSB(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic        m2r;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rwd;
    logic        exp_mis;
    int          exp_stall;
  } vec_t;

  vec_t vecs[10];
  int   checks;
  int   errors;

  // Transaction-level reference: memory contents, last loaded word, misalign flag.
  logic [15:0] model_mem [1024];
  logic [15:0] model_rdata;
  logic        model_mis;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 1024; i++) model_mem[i] = 16'h0000;
    model_rdata = 16'h0000;
    model_mis   = 1'b0;
  endtask

  task automatic modelOp(input logic rd, input logic wr, input logic m2r,
                         input logic [15:0] addr, input logic [15:0] data,
                         output logic [15:0] exp_rwd, output logic exp_mis,
                         output int exp_stall);
    int word;
    word = (int'(addr) / 2) % 1024;
    if (rd || wr) begin
      model_mis = (addr % 2) != 0;
      if (rd) model_rdata = model_mem[word];
      else    model_mem[word] = data;
      exp_stall = LAT;
    end else begin
      exp_stall = 0;
    end
    exp_rwd = m2r ? model_rdata : addr;
    exp_mis = model_mis;
  endtask

  // Present one op and follow it to completion (or one cycle for a non-memory op).
  task automatic applyStimulus(input logic rd, input logic wr, input logic m2r,
                               input logic [15:0] addr, input logic [15:0] data,
                               output int nstall, output logic done, output logic done_stall,
                               output logic [15:0] rwd, output logic mis, output logic timeout);
    nstall = 0; done = 1'b0; done_stall = 1'b0; rwd = '0; mis = 1'b0; timeout = 1'b1;
    @(negedge clk);
    bus.readEn = rd; bus.writeEn = wr; bus.memToReg = m2r;
    bus.mem_addr = addr; bus.data_in = data;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (bus.wb_valid) begin
        done = 1'b1; done_stall = bus.stall; rwd = bus.regWriteData; mis = bus.misalign;
        timeout = 1'b0;
        break;
      end else if (bus.stall) begin
        nstall++;
      end else begin
        rwd = bus.regWriteData; mis = bus.misalign;
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      bus.data_in = 16'($urandom);
    end
  endtask

  task automatic runOp(input string name, input logic rd, input logic wr, input logic m2r,
                       input logic [15:0] addr, input logic [15:0] data,
                       input logic [15:0] exp_rwd, input logic exp_mis, input int exp_stall);
    int nstall; logic done, done_stall, mis, timeout; logic [15:0] rwd;
    applyStimulus(rd, wr, m2r, addr, data, nstall, done, done_stall, rwd, mis, timeout);
    if (timeout) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout waiting for wb_valid got stall=%0d expected done", name, nstall);
    end else begin
      checkOutput({name, "_wb_valid"}, 32'(done), 32'(rd | wr));
      checkOutput({name, "_stall_cycles"}, 32'(nstall), 32'(exp_stall));
      checkOutput({name, "_done_stall"}, 32'(done_stall), 32'd0);
      checkOutput({name, "_rwd"}, 32'(rwd), 32'(exp_rwd));
      checkOutput({name, "_misalign"}, 32'(mis), 32'(exp_mis));
    end
  endtask

  // Main test sequence.
  initial begin
    logic [15:0] e_rwd; logic e_mis; int e_stall;
    logic [15:0] raddr, rdata; logic rrd, rwr, rm2r; int op;
    checks = 0; errors = 0;
    {bus.readEn, bus.writeEn, bus.memToReg} = 3'b000;
    bus.mem_addr = '0; bus.data_in = '0;
    {bus1.readEn, bus1.writeEn, bus1.memToReg} = 3'b000;
    bus1.mem_addr = '0; bus1.data_in = '0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0010, 1'b0, LAT};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, LAT};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, LAT};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'hBEEF, 1'b0, LAT};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, LAT};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h5A5A, 16'h0000, 16'h5A5A, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0801, 16'h00AA, 16'h0801, 1'b1, LAT};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h00AA, 1'b0, LAT};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, LAT};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h1111, 16'h0000, 16'hBEEF, 1'b0, 0};

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_stall", 32'(bus.stall), 32'd0);
    checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    checkOutput("reset_misalign", 32'(bus.misalign), 32'd0);
    bus.memToReg = 1'b1;
    #1;
    checkOutput("reset_rwd_mem", 32'(bus.regWriteData), 32'd0);
    bus.memToReg = 1'b0; bus.mem_addr = 16'hC3C3;
    #1;
    checkOutput("reset_rwd_addr", 32'(bus.regWriteData), 32'hC3C3);
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 10; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].m2r, vecs[i].addr,
            vecs[i].data, vecs[i].exp_rwd, vecs[i].exp_mis, vecs[i].exp_stall);
    end

    // Reset in the second BUSY cycle of a store must abort it.
    @(negedge clk);
    bus.readEn = 1'b0; bus.writeEn = 1'b1; bus.memToReg = 1'b0;
    bus.mem_addr = 16'h0020; bus.data_in = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("abort_busy_stall", 32'(bus.stall), 32'd1);
    #1;
    rst_n = 1'b1; bus.writeEn = 1'b0;
    #1;
    checkOutput("abort_stall_drop", 32'(bus.stall), 32'd0);
    checkOutput("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    modelOp(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0, e_rwd, e_mis, e_stall);
    runOp("abort_read20", 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0, e_rwd, e_mis, e_stall);
    modelOp(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, e_rwd, e_mis, e_stall);
    runOp("abort_read10", 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, e_rwd, e_mis, e_stall);

    // Randomized ops over a small set of words, with aliasing upper bits.
    for (int i = 0; i < 80; i++) begin
      op    = $urandom_range(0, 3);
      rrd   = (op == 1) || (op == 3);
      rwr   = (op == 2) || (op == 3);
      rm2r  = 1'($urandom);
      raddr = 16'($urandom);
      raddr[10:1] = 10'($urandom_range(0, 15));
      raddr[0]    = ($urandom_range(0, 3) == 0);
      rdata = 16'($urandom);
      modelOp(rrd, rwr, rm2r, raddr, rdata, e_rwd, e_mis, e_stall);
      runOp($sformatf("rand%0d", i), rrd, rwr, rm2r, raddr, rdata, e_rwd, e_mis, e_stall);
    end
    @(negedge clk);
    {bus.readEn, bus.writeEn} = 2'b00;

    // Single-cycle build: one stall cycle, DONE next, read data returned.
    bus1.readEn = 1'b0; bus1.writeEn = 1'b1; bus1.memToReg = 1'b0;
    bus1.mem_addr = 16'h0006; bus1.data_in = 16'h4444;
    #1;
    checkOutput("l1_wr_stall", 32'(bus1.stall), 32'd1);
    checkOutput("l1_wr_idle_wb", 32'(bus1.wb_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("l1_wr_done", 32'(bus1.wb_valid), 32'd1);
    checkOutput("l1_wr_done_stall", 32'(bus1.stall), 32'd0);
    @(negedge clk);
    bus1.readEn = 1'b1; bus1.writeEn = 1'b0; bus1.memToReg = 1'b1;
    bus1.data_in = 16'h0000;
    #1;
    checkOutput("l1_rd_stall", 32'(bus1.stall), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("l1_rd_done", 32'(bus1.wb_valid), 32'd1);
    checkOutput("l1_rd_done_stall", 32'(bus1.stall), 32'd0);
    checkOutput("l1_rd_data", 32'(bus1.regWriteData), 32'h4444);
    @(negedge clk);
    {bus1.readEn, bus1.writeEn} = 2'b00;
    #1;
    checkOutput("l1_idle_wb", 32'(bus1.wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
